wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the in-order pipeline writeback path and a multi-cycle unit (divider/long-latency load return).
- Pipeline writes have priority.
- Multi-cycle results are buffered in a small FIFO and drained into free write slots.
- A starvation guard forces a pipeline stall bubble so buffered results always drain.

Parameters:
- DATA_W, 24, register data width.
- ADDR_W, 4, register address width.
- FIFO_DEPTH, 4, multi-cycle result buffer entries (power of two, >=2).
- STARVE_MAX, 3, consecutive pipeline grants tolerated while the FIFO is non-empty.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pipe_we  in  1  pipeline writeback request (writeback enable out of WB stage).
- pipe_waddr  in  ADDR_W  pipeline destination register.
- pipe_wdata  in  DATA_W  pipeline writeback data.
- pipe_stall  out  1  pipeline must hold its WB instruction this cycle.
- mc_valid  in  1  multi-cycle result valid.
- mc_ready  out  1  FIFO can accept a result.
- mc_waddr  in  ADDR_W  multi-cycle destination register.
- mc_wdata  in  DATA_W  multi-cycle result data.
- rf_we  out  1  register-file write enable (registered).
- rf_waddr  out  ADDR_W  register-file write address (registered).
- rf_wdata  out  DATA_W  register-file write data (registered).
- fifo_count  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async, rst_n=0):
  - FIFO emptied; fifo_count=0.
  - State NORMAL; starvation counter=0.
  - rf_we=0, rf_waddr=0, rf_wdata=0; pipe_stall=0; mc_ready=1 once rst_n deasserts.
  - Reset mid-operation discards all buffered results and any in-flight grant.
- FIFO push:
  - mc_ready = (fifo_count != FIFO_DEPTH), from registered count only.
  - Push when mc_valid && mc_ready. No push when full, even if a pop occurs that cycle.
  - mc_* must be held stable while mc_valid && !mc_ready.
- FIFO pop: only by arbiter grant.
  - A same-cycle push to an empty FIFO is not grantable that cycle (no bypass); earliest grant is the next cycle.
  - Simultaneous push and pop: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- State machine, NORMAL:
  - pipe_stall=0.
  - Grant pipe if pipe_we=1; otherwise grant FIFO head if fifo_count>0; otherwise no grant.
  - Starvation counter increments when pipe is granted while fifo_count>0. It clears on any FIFO grant or whenever fifo_count=0.
  - If the counter would reach STARVE_MAX, go to FORCE next cycle and clear the counter.
- State machine, FORCE (one cycle, Moore):
  - pipe_stall=1.
  - Grant FIFO head unconditionally (FIFO is guaranteed non-empty since only grants pop).
  - pipe_we is ignored; upstream re-presents the same writeback next cycle.
  - Always return to NORMAL.
- Output timing:
  - Granted address/data are registered into rf_*, with rf_we=1 the cycle after the grant (1-cycle latency).
  - No grant gives rf_we=0; rf_waddr/rf_wdata hold their previous values.
- Width rules: data and address pass unmodified; no arithmetic on payload.
- Ordering:
  - Pipeline-vs-FIFO writes to the same register commit in grant order.
  - WAW correctness across the two sources is the issue scoreboard's responsibility, not this block's.

Decomposition:
- Shared package wb_pkg:
  - DATA_W/ADDR_W constants.
  - typedef wb_req_t {we, waddr, wdata}.
  - enum arb_state_e {ARB_NORMAL, ARB_FORCE}.
- One natural sub-module: wb_result_fifo (synchronous FIFO, DEPTH/width parameters, push/pop/count, async active-low reset).
- The arbiter FSM and output registers stay in wb_port_arbiter.

Test Plan:
- Reset, then pipe_we=1 addr=3 data=0x00ABCD for 1 cycle -> next cycle rf_we=1, rf_waddr=3, rf_wdata=0x00ABCD; pipe_stall=0.
- Pipe idle; mc pushes addr=5 data=0x123456 at cycle t -> fifo_count=1 at t+1, grant at t+1, rf write at t+2, fifo_count=0 at t+2.
- One FIFO entry plus continuous pipe_we=1 -> 3 pipe writes, then pipe_stall=1 for exactly one cycle, FIFO entry written next, pipe resumes; pipe data never lost.
- Push 5 results back-to-back with pipe_we=1 and pipe_stall honoured by the bench:
  - mc_ready drops after 4 accepted; count holds at 4.
  - Entries drain in push order via FORCE cycles.
  - 5th result is accepted once a pop frees space.
- Full FIFO with simultaneous push attempt and FORCE pop -> push refused that cycle (mc_ready=0); count 4 to 3; accepted next cycle.
- Assert rst_n=0 asynchronously with 3 entries buffered and FORCE active -> immediately rf_we=0, pipe_stall=0, fifo_count=0; after release, no stale entry is ever written.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback port arbiter.
// Payload widths default the arbiter parameters.
package wb_pkg;

    localparam int WB_DATA_W = 24;
    localparam int WB_ADDR_W = 4;

    typedef struct packed {
        logic                 we;
        logic [WB_ADDR_W-1:0] waddr;
        logic [WB_DATA_W-1:0] wdata;
    } wb_req_t;

    typedef enum logic {
        ARB_NORMAL = 1'b0,
        ARB_FORCE  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/wb_result_fifo.sv
// Small synchronous FIFO buffering multi-cycle results awaiting a write slot.
// The caller gates push/pop; pointers wrap naturally (DEPTH is a power of two).
module wb_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 28
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between pipeline writeback and
// buffered multi-cycle results, with a starvation guard forcing a drain.
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_W     = WB_DATA_W,
    parameter int ADDR_W     = WB_ADDR_W,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         pipe_we,
    input  logic [ADDR_W-1:0]            pipe_waddr,
    input  logic [DATA_W-1:0]            pipe_wdata,
    output logic                         pipe_stall,
    input  logic                         mc_valid,
    output logic                         mc_ready,
    input  logic [ADDR_W-1:0]            mc_waddr,
    input  logic [DATA_W-1:0]            mc_wdata,
    output logic                         rf_we,
    output logic [ADDR_W-1:0]            rf_waddr,
    output logic [DATA_W-1:0]            rf_wdata,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    arb_state_e state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;

    logic                 push;
    logic                 pipe_gnt;
    logic                 fifo_gnt;
    logic                 fifo_busy;
    logic [ADDR_W-1:0]    head_addr;
    logic [DATA_W-1:0]    head_data;

    // Readiness comes from the registered count only: no push into a
    // full buffer even when the same cycle pops.
    assign mc_ready  = (fifo_count != CW'(FIFO_DEPTH));
    assign push      = mc_valid && mc_ready;
    assign fifo_busy = (fifo_count != '0);

    wb_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ADDR_W + DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   ({mc_waddr, mc_wdata}),
        .pop   (fifo_gnt),
        .dout  ({head_addr, head_data}),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARB_NORMAL;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        state_d  = ARB_NORMAL;
        starve_d = '0;
        pipe_gnt = 1'b0;
        fifo_gnt = 1'b0;
        unique case (state_q)
            ARB_FORCE: begin
                fifo_gnt = 1'b1;
            end
            ARB_NORMAL: begin
                if (pipe_we) begin
                    pipe_gnt = 1'b1;
                    if (fifo_busy) begin
                        if (starve_q == SW'(STARVE_MAX - 1)) begin
                            state_d = ARB_FORCE;
                        end else begin
                            starve_d = starve_q + SW'(1);
                        end
                    end
                end else if (fifo_busy) begin
                    fifo_gnt = 1'b1;
                end
            end
        endcase
    end

    assign pipe_stall = (state_q == ARB_FORCE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= pipe_gnt || fifo_gnt;
            if (pipe_gnt) begin
                rf_waddr <= pipe_waddr;
                rf_wdata <= pipe_wdata;
            end else if (fifo_gnt) begin
                rf_waddr <= head_addr;
                rf_wdata <= head_data;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: grants, starvation drain,
// full-buffer back-pressure and asynchronous reset.
module tb_wb_port_arbiter;
    import wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pipe_we = 1'b0;
    logic [3:0]  pipe_waddr = '0;
    logic [23:0] pipe_wdata = '0;
    logic        pipe_stall;
    logic        mc_valid = 1'b0;
    logic        mc_ready;
    logic [3:0]  mc_waddr = '0;
    logic [23:0] mc_wdata = '0;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [23:0] rf_wdata;
    logic [2:0]  fifo_count;

    int n_tests = 0;
    int n_fail  = 0;

    wb_port_arbiter #(
        .DATA_W     (24),
        .ADDR_W     (4),
        .FIFO_DEPTH (4),
        .STARVE_MAX (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pipe_we    (pipe_we),
        .pipe_waddr (pipe_waddr),
        .pipe_wdata (pipe_wdata),
        .pipe_stall (pipe_stall),
        .mc_valid   (mc_valid),
        .mc_ready   (mc_ready),
        .mc_waddr   (mc_waddr),
        .mc_wdata   (mc_wdata),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pipe(input logic we,
                            input logic [3:0] a,
                            input logic [23:0] d);
        pipe_we    = we;
        pipe_waddr = a;
        pipe_wdata = d;
    endtask

    task automatic set_mc(input logic v,
                          input logic [3:0] a,
                          input logic [23:0] d);
        mc_valid = v;
        mc_waddr = a;
        mc_wdata = d;
    endtask

    // Expected write order while both sources compete:
    // <100 is pipe item i, >=100 is buffered item (v-100).
    int exp_seq [21] = '{0, 1, 2, 3, 100,
                         4, 5, 6, 101,
                         7, 8, 9, 102,
                         10, 11, 12, 103,
                         13, 14, 15, 104};

    initial begin
        wb_req_t er;
        int q;
        int m;
        logic st;
        logic rdy;
        logic v;

        // reset state
        #2;
        check("rst_rf_we", 32'(rf_we), 0);
        check("rst_rf_waddr", 32'(rf_waddr), 0);
        check("rst_rf_wdata", 32'(rf_wdata), 0);
        check("rst_stall", 32'(pipe_stall), 0);
        check("rst_count", 32'(fifo_count), 0);
        step();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_mc_ready", 32'(mc_ready), 1);
        step();

        // single pipeline write
        set_pipe(1'b1, 4'd3, 24'h00ABCD);
        step();
        check("p1_we", 32'(rf_we), 1);
        check("p1_addr", 32'(rf_waddr), 3);
        check("p1_data", 32'(rf_wdata), 32'h00ABCD);
        check("p1_stall", 32'(pipe_stall), 0);
        set_pipe(1'b0, 4'd0, 24'd0);
        step();
        check("p1_idle_we", 32'(rf_we), 0);
        check("p1_hold_addr", 32'(rf_waddr), 3);
        check("p1_hold_data", 32'(rf_wdata), 32'h00ABCD);

        // single buffered result, pipe idle
        set_mc(1'b1, 4'd5, 24'h123456);
        step();
        check("mc1_count1", 32'(fifo_count), 1);
        check("mc1_no_bypass", 32'(rf_we), 0);
        set_mc(1'b0, 4'd0, 24'd0);
        step();
        check("mc1_we", 32'(rf_we), 1);
        check("mc1_addr", 32'(rf_waddr), 5);
        check("mc1_data", 32'(rf_wdata), 32'h123456);
        check("mc1_count0", 32'(fifo_count), 0);

        // one buffered entry vs continuous pipeline
        set_mc(1'b1, 4'd7, 24'h777777);
        step();
        check("sv_count", 32'(fifo_count), 1);
        set_mc(1'b0, 4'd0, 24'd0);
        set_pipe(1'b1, 4'd1, 24'h100001);
        step();
        check("sv_p1", 32'(rf_wdata), 32'h100001);
        check("sv_p1_stall", 32'(pipe_stall), 0);
        set_pipe(1'b1, 4'd2, 24'h100002);
        step();
        check("sv_p2", 32'(rf_wdata), 32'h100002);
        check("sv_p2_stall", 32'(pipe_stall), 0);
        set_pipe(1'b1, 4'd3, 24'h100003);
        step();
        check("sv_p3", 32'(rf_wdata), 32'h100003);
        check("sv_force_stall", 32'(pipe_stall), 1);
        set_pipe(1'b1, 4'd4, 24'h100004);
        step();
        check("sv_mc_we", 32'(rf_we), 1);
        check("sv_mc_addr", 32'(rf_waddr), 7);
        check("sv_mc_data", 32'(rf_wdata), 32'h777777);
        check("sv_unstall", 32'(pipe_stall), 0);
        check("sv_count0", 32'(fifo_count), 0);
        step();
        check("sv_p4_addr", 32'(rf_waddr), 4);
        check("sv_p4_data", 32'(rf_wdata), 32'h100004);
        set_pipe(1'b0, 4'd0, 24'd0);
        step();
        check("sv_idle", 32'(rf_we), 0);

        // five back-to-back results against a busy pipeline
        q = 0;
        m = 0;
        for (int cyc = 0; cyc < 21; cyc++) begin
            set_pipe(1'b1, 4'((q % 8) + 8), 24'(32'hA00000 + q));
            if (m < 5) begin
                set_mc(1'b1, 4'(m + 1), 24'(32'hC00000 + m));
            end else begin
                set_mc(1'b0, 4'd0, 24'd0);
            end
            st  = pipe_stall;
            rdy = mc_ready;
            v   = mc_valid;
            if (cyc == 4) begin
                check("full_ready", 32'(mc_ready), 0);
                check("full_count", 32'(fifo_count), 4);
                check("full_stall", 32'(pipe_stall), 1);
            end
            if (cyc == 5) begin
                check("refill_ready", 32'(mc_ready), 1);
            end
            step();
            if (!st) q++;
            if (v && rdy) m++;
            if (exp_seq[cyc] >= 100) begin
                er.we    = 1'b1;
                er.waddr = 4'(exp_seq[cyc] - 100 + 1);
                er.wdata = 24'(32'hC00000 + exp_seq[cyc] - 100);
            end else begin
                er.we    = 1'b1;
                er.waddr = 4'((exp_seq[cyc] % 8) + 8);
                er.wdata = 24'(32'hA00000 + exp_seq[cyc]);
            end
            check($sformatf("bb_we_%0d", cyc), 32'(rf_we), 32'(er.we));
            check($sformatf("bb_addr_%0d", cyc),
                  32'(rf_waddr), 32'(er.waddr));
            check($sformatf("bb_data_%0d", cyc),
                  32'(rf_wdata), 32'(er.wdata));
            if (cyc == 4) begin
                check("full_pop_count", 32'(fifo_count), 3);
            end
            if (cyc == 5) begin
                check("refill_count", 32'(fifo_count), 4);
            end
        end
        check("bb_all_pushed", 32'(m), 5);
        check("bb_drained", 32'(fifo_count), 0);
        set_pipe(1'b0, 4'd0, 24'd0);
        set_mc(1'b0, 4'd0, 24'd0);
        step();

        // async reset while FORCE is active with 3 buffered entries
        set_pipe(1'b1, 4'd2, 24'hB00000);
        set_mc(1'b1, 4'd9, 24'hD00000);
        step();
        set_mc(1'b1, 4'd10, 24'hD00001);
        step();
        set_mc(1'b1, 4'd11, 24'hD00002);
        step();
        set_mc(1'b0, 4'd0, 24'd0);
        step();
        check("ar_pre_stall", 32'(pipe_stall), 1);
        check("ar_pre_count", 32'(fifo_count), 3);
        check("ar_pre_we", 32'(rf_we), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_we", 32'(rf_we), 0);
        check("ar_waddr", 32'(rf_waddr), 0);
        check("ar_wdata", 32'(rf_wdata), 0);
        check("ar_stall", 32'(pipe_stall), 0);
        check("ar_count", 32'(fifo_count), 0);
        set_pipe(1'b0, 4'd0, 24'd0);
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ar_ready", 32'(mc_ready), 1);
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("ar_no_stale_%0d", i), 32'(rf_we), 0);
            check($sformatf("ar_empty_%0d", i),
                  32'(fifo_count), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
